// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes
// (same values the pipeline controller uses), fetch FSM states and the
// instruction word that stands for a bubble in the IF/ID register.
package if_fetch_stage_pkg;

    localparam logic [2:0] PC_NEXT = 3'd0;
    localparam logic [2:0] PC_JUMP = 3'd1;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_BEQ  = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;

    // REQ: a request is outstanding on the instruction-memory port.
    // HOLD: a fetched word is buffered because ID could not accept it.
    // DISCARD: a request is outstanding but its data belongs to a dead path.
    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_pc_target_gen.sv
// Redirect target computation for the instruction currently in ID.
// Purely combinational; the fetch stage decides whether the target is used.
module pc_target_gen
    import if_fetch_stage_pkg::*;
(
    input  logic [2:0]  i_pc_src,
    input  logic [31:0] i_inst_id,
    input  logic [31:0] i_pc4_id,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_target
);

    logic [31:0] w_branch_offset;

    // Branch displacement is a signed word offset relative to PC+4.
    assign w_branch_offset = {{14{i_inst_id[15]}}, i_inst_id[15:0], 2'b00};

    // Select the target for the requested redirect kind; PC+4 otherwise.
    always_comb begin
        o_target = i_pc4_id;
        case (i_pc_src)
            PC_JUMP: o_target = {i_pc4_id[31:28], i_inst_id[25:0], 2'b00};
            PC_JR:   o_target = i_rs_data;
            PC_BEQ,
            PC_BNE:  o_target = i_pc4_id + w_branch_offset;
            default: o_target = i_pc4_id;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. Holds the PC,
// talks to a variable-latency instruction memory through a req/ack
// handshake, buffers a fetched word while ID is stalled and drops data
// belonging to a path abandoned by a redirect or an IF reset.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rst,
    input  logic        if_en,
    input  logic        id_rst,
    input  logic        id_en,
    input  logic [2:0]  pc_src,
    input  logic [31:0] id_rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic        id_valid,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc4_id
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_hold_data;
    logic         w_hold_load;
    logic         r_id_valid;
    logic [31:0]  r_inst_id;
    logic [31:0]  r_pc_id;
    logic [31:0]  r_pc4_id;
    logic [31:0]  w_target;
    logic [31:0]  w_fetch_word;
    logic         w_if_valid;
    logic         w_redirect;
    logic         w_transfer;
    logic         w_fetch_pending;

    pc_target_gen u_pc_target_gen (
        .i_pc_src  (pc_src),
        .i_inst_id (r_inst_id),
        .i_pc4_id  (r_pc4_id),
        .i_rs_data (id_rs_data),
        .o_target  (w_target)
    );

    // A word is available straight from memory on ack, or from the buffer.
    assign w_if_valid   = ((r_state == S_REQ) && imem_ack) || (r_state == S_HOLD);
    assign w_fetch_word = (r_state == S_HOLD) ? r_hold_data : imem_data;

    // A redirect only takes effect while ID is advancing its instruction.
    assign w_redirect = r_id_valid && id_en && (pc_src != PC_NEXT);

    // IF resets and ID flushes both block a word from entering ID; a word
    // blocked by an ID flush stays buffered and is offered again later.
    assign w_transfer = if_en && id_en && w_if_valid && !w_redirect && !if_rst && !id_rst;

    // A memory request is still in flight and its data has not come back.
    assign w_fetch_pending = (r_state != S_HOLD) && !imem_ack;

    assign imem_req  = (r_state == S_REQ) && !rst;
    assign imem_addr = r_pc;
    assign if_valid  = w_if_valid;
    assign id_valid  = r_id_valid;
    assign inst_id   = r_inst_id;
    assign pc_id     = r_pc_id;
    assign pc4_id    = r_pc4_id;

    // Next FSM state and PC: IF reset beats redirect, which beats normal flow.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_hold_load  = 1'b0;
        if (if_rst || w_redirect) begin
            w_pc_next    = if_rst ? RESET_PC : w_target;
            w_state_next = w_fetch_pending ? S_DISCARD : S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        if (w_transfer) begin
                            w_pc_next = r_pc + 32'd4;
                        end else begin
                            w_hold_load  = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_transfer) begin
                        w_pc_next    = r_pc + 32'd4;
                        w_state_next = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        w_state_next = S_REQ;
                    end
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    // FSM state and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Buffer a fetched word that ID could not take in its ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_data <= BUBBLE_INST;
        end else if (w_hold_load) begin
            r_hold_data <= imem_data;
        end
    end

    // IF/ID register: flush beats transfer; an advancing ID with nothing to
    // take loads a bubble; a stalled ID keeps its contents.
    always_ff @(posedge clk) begin
        if (rst || id_rst) begin
            r_id_valid <= 1'b0;
            r_inst_id  <= BUBBLE_INST;
            r_pc_id    <= 32'h0;
            r_pc4_id   <= 32'h0;
        end else if (w_transfer) begin
            r_id_valid <= 1'b1;
            r_inst_id  <= w_fetch_word;
            r_pc_id    <= r_pc;
            r_pc4_id   <= r_pc + 32'd4;
        end else if (id_en) begin
            r_id_valid <= 1'b0;
            r_inst_id  <= BUBBLE_INST;
            r_pc_id    <= 32'h0;
            r_pc4_id   <= 32'h0;
        end
    end

endmodule
